// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with prefix tracking, modifiers
// and a first-word-fall-through character FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_data,
    input  logic       scan_data_valid,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_rd,
    output logic       fifo_full,
    output logic       overflow,
    output logic       caps_lock
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_SKIP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        valid_q, take_q;
    logic [7:0]  byte_q;
    logic        lshift, rshift, lctrl, rctrl;
    logic        key_ev, key_ext, key_make;
    logic        lt_hit, dg_hit, ch_hit;
    logic [4:0]  lt_idx;
    logic [3:0]  dg_idx;
    logic [7:0]  ch;
    logic        shift, ctrl;
    logic [7:0]  char_q;
    logic        char_v;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          push, pop;

    assign shift = lshift | rshift;
    assign ctrl  = lctrl | rctrl;

    // Byte capture on rising edge of the receiver strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            take_q  <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            valid_q <= scan_data_valid;
            take_q  <= scan_data_valid & ~valid_q;
            byte_q  <= scan_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        key_ev   = 1'b0;
        key_ext  = 1'b0;
        key_make = 1'b0;
        if (take_q) begin
            case (state_q)
                S_IDLE: begin
                    case (byte_q)
                        8'hE0: state_d = S_E0;
                        8'hF0: state_d = S_F0;
                        8'hE1: begin
                            state_d = S_SKIP;
                            skip_d  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE,
                        8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
                        default: begin
                            key_ev   = 1'b1;
                            key_make = 1'b1;
                        end
                    endcase
                end
                S_E0: begin
                    state_d = S_IDLE;
                    if (byte_q == 8'hF0) begin
                        state_d = S_E0F0;
                    end else if (byte_q != 8'h12) begin
                        key_ev   = 1'b1;
                        key_ext  = 1'b1;
                        key_make = 1'b1;
                    end
                end
                S_F0: begin
                    state_d = S_IDLE;
                    key_ev  = 1'b1;
                end
                S_E0F0: begin
                    state_d = S_IDLE;
                    key_ev  = 1'b1;
                    key_ext = 1'b1;
                end
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        lt_hit = 1'b1;
        lt_idx = 5'd0;
        case (byte_q)
            8'h1C: lt_idx = 5'd0;
            8'h32: lt_idx = 5'd1;
            8'h21: lt_idx = 5'd2;
            8'h23: lt_idx = 5'd3;
            8'h24: lt_idx = 5'd4;
            8'h2B: lt_idx = 5'd5;
            8'h34: lt_idx = 5'd6;
            8'h33: lt_idx = 5'd7;
            8'h43: lt_idx = 5'd8;
            8'h3B: lt_idx = 5'd9;
            8'h42: lt_idx = 5'd10;
            8'h4B: lt_idx = 5'd11;
            8'h3A: lt_idx = 5'd12;
            8'h31: lt_idx = 5'd13;
            8'h44: lt_idx = 5'd14;
            8'h4D: lt_idx = 5'd15;
            8'h15: lt_idx = 5'd16;
            8'h2D: lt_idx = 5'd17;
            8'h1B: lt_idx = 5'd18;
            8'h2C: lt_idx = 5'd19;
            8'h3C: lt_idx = 5'd20;
            8'h2A: lt_idx = 5'd21;
            8'h1D: lt_idx = 5'd22;
            8'h22: lt_idx = 5'd23;
            8'h35: lt_idx = 5'd24;
            8'h1A: lt_idx = 5'd25;
            default: lt_hit = 1'b0;
        endcase
    end

    always_comb begin
        dg_hit = 1'b1;
        dg_idx = 4'd0;
        case (byte_q)
            8'h45: dg_idx = 4'd0;
            8'h16: dg_idx = 4'd1;
            8'h1E: dg_idx = 4'd2;
            8'h26: dg_idx = 4'd3;
            8'h25: dg_idx = 4'd4;
            8'h2E: dg_idx = 4'd5;
            8'h36: dg_idx = 4'd6;
            8'h3D: dg_idx = 4'd7;
            8'h3E: dg_idx = 4'd8;
            8'h46: dg_idx = 4'd9;
            default: dg_hit = 1'b0;
        endcase
    end

    always_comb begin
        ch_hit = 1'b1;
        ch     = 8'h00;
        if (key_ext) begin
            case (byte_q)
                8'h5A: ch = 8'h0D;
                8'h71: ch = 8'h7F;
                8'h75: ch = 8'h80;
                8'h72: ch = 8'h81;
                8'h6B: ch = 8'h82;
                8'h74: ch = 8'h83;
                default: ch_hit = 1'b0;
            endcase
        end else if (lt_hit) begin
            if (ctrl)
                ch = 8'h01 + {3'b000, lt_idx};
            else if (shift ^ caps_lock)
                ch = 8'h41 + {3'b000, lt_idx};
            else
                ch = 8'h61 + {3'b000, lt_idx};
        end else if (dg_hit) begin
            if (!shift) begin
                ch = 8'h30 + {4'h0, dg_idx};
            end else begin
                case (dg_idx)
                    4'd0: ch = 8'h29;
                    4'd1: ch = 8'h21;
                    4'd2: ch = 8'h40;
                    4'd3: ch = 8'h23;
                    4'd4: ch = 8'h24;
                    4'd5: ch = 8'h25;
                    4'd6: ch = 8'h5E;
                    4'd7: ch = 8'h26;
                    4'd8: ch = 8'h2A;
                    default: ch = 8'h28;
                endcase
            end
        end else begin
            case (byte_q)
                8'h0E: ch = shift ? 8'h7E : 8'h60;
                8'h4E: ch = shift ? 8'h5F : 8'h2D;
                8'h55: ch = shift ? 8'h2B : 8'h3D;
                8'h54: ch = shift ? 8'h7B : 8'h5B;
                8'h5B: ch = shift ? 8'h7D : 8'h5D;
                8'h5D: ch = shift ? 8'h7C : 8'h5C;
                8'h4C: ch = shift ? 8'h3A : 8'h3B;
                8'h52: ch = shift ? 8'h22 : 8'h27;
                8'h41: ch = shift ? 8'h3C : 8'h2C;
                8'h49: ch = shift ? 8'h3E : 8'h2E;
                8'h4A: ch = shift ? 8'h3F : 8'h2F;
                8'h29: ch = 8'h20;
                8'h5A: ch = 8'h0D;
                8'h66: ch = 8'h08;
                8'h0D: ch = 8'h09;
                8'h76: ch = 8'h1B;
                default: ch_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            skip_q    <= 3'd0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_lock <= 1'b0;
            char_q    <= 8'h00;
            char_v    <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            char_q  <= ch;
            char_v  <= key_ev & key_make & ch_hit;
            if (key_ev && !key_ext) begin
                if (byte_q == 8'h12) lshift <= key_make;
                if (byte_q == 8'h59) rshift <= key_make;
                if (byte_q == 8'h14) lctrl <= key_make;
                if (byte_q == 8'h58 && key_make) caps_lock <= ~caps_lock;
            end
            if (key_ev && key_ext && byte_q == 8'h14) rctrl <= key_make;
        end
    end

    // A pop in the same cycle frees the slot for a write into a full FIFO
    assign ascii_valid = (count_q != '0);
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign pop         = ascii_rd & ascii_valid;
    assign push        = char_v & (~fifo_full | pop);
    assign ascii_data  = ascii_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= char_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10: count_q <= count_q + 1'b1;
                2'b01: count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (char_v && !push) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed protocol cases plus random
// byte streams against a prefix/modifier/queue reference model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_data;
  logic       scan_data_valid;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_rd;
  logic       fifo_full;
  logic       overflow;
  logic       caps_lock;

  int n_chk = 0;
  int n_err = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_data      (scan_data),
    .scan_data_valid(scan_data_valid),
    .ascii_data     (ascii_data),
    .ascii_valid    (ascii_valid),
    .ascii_rd       (ascii_rd),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .caps_lock      (caps_lock)
  );

  always #5 clk = ~clk;

  logic [7:0] let_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pun_codes [11] = '{
    8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
    8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] pun_lo [11] = '{
    8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
    8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] pun_hi [11] = '{
    8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
    8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  string dig_hi = ")!@#$%^&*(";

  bit         m_ext, m_brk, m_lsh, m_rsh, m_lct, m_rct, m_caps, m_ovf;
  int         m_skip;
  logic [7:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_char(input logic [7:0] c, input bit ext);
    bit sh;
    bit ct;
    sh = m_lsh | m_rsh;
    ct = m_lct | m_rct;
    if (ext) begin
      case (c)
        8'h5A: return 'h0D;
        8'h71: return 'h7F;
        8'h75: return 'h80;
        8'h72: return 'h81;
        8'h6B: return 'h82;
        8'h74: return 'h83;
        default: return -1;
      endcase
    end
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == c)
        return ct ? i + 1 :
               ((sh ^ m_caps) ? 'h41 + i : 'h61 + i);
    for (int i = 0; i < 10; i++)
      if (dig_codes[i] == c)
        return sh ? int'(dig_hi.getc(i)) : 'h30 + i;
    for (int i = 0; i < 11; i++)
      if (pun_codes[i] == c)
        return sh ? int'(pun_hi[i]) : int'(pun_lo[i]);
    case (c)
      8'h29: return 'h20;
      8'h5A: return 'h0D;
      8'h66: return 'h08;
      8'h0D: return 'h09;
      8'h76: return 'h1B;
      default: return -1;
    endcase
  endfunction

  function automatic void model_key(input logic [7:0] c, input bit ext,
                                    input bit make);
    int v;
    if (make) begin
      v = model_char(c, ext);
      if (v >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(v[7:0]);
        else m_ovf = 1;
      end
    end
    if (!ext && c == 8'h12) m_lsh = make;
    if (!ext && c == 8'h59) m_rsh = make;
    if (!ext && c == 8'h14) m_lct = make;
    if (ext && c == 8'h14) m_rct = make;
    if (!ext && c == 8'h58 && make) m_caps = ~m_caps;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk) begin
      model_key(b, m_ext, 0);
      m_ext = 0;
      m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        if (b != 8'h12) model_key(b, 1, 1);
        m_ext = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_skip = 7;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: model_key(b, 0, 1);
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0;
    m_caps = 0; m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_pop();
    if (m_q.size() > 0) void'(m_q.pop_front());
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    scan_data_valid = 1'b0;
    ascii_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    scan_data = b;
    scan_data_valid = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    scan_data_valid = 1'b0;
    repeat (4) @(negedge clk);
    model_byte(b);
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send(s[i], 1);
  endtask

  task automatic pop();
    @(negedge clk);
    ascii_rd = 1'b1;
    @(negedge clk);
    ascii_rd = 1'b0;
    model_pop();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] v);
    check({tag, "_valid"}, ascii_valid, 1);
    check(tag, ascii_data, v);
    pop();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, ascii_valid, 0);
    check({tag, "_data"}, ascii_data, 0);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_caps"}, caps_lock, 0);
  endtask

  task automatic send_with_rd(input logic [7:0] b);
    @(negedge clk);
    scan_data = b;
    scan_data_valid = 1'b1;
    @(negedge clk);
    scan_data_valid = 1'b0;
    @(negedge clk);
    ascii_rd = 1'b1;
    @(negedge clk);
    ascii_rd = 1'b0;
    repeat (2) @(negedge clk);
    model_pop();
    model_byte(b);
  endtask

  initial begin
    reset = 1'b1;
    scan_data = 8'h00;
    scan_data_valid = 1'b0;
    ascii_rd = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst0");

    do_reset();
    send_seq('{8'h1C, 8'hF0, 8'h1C});
    pop_expect("t1_a", 8'h61);
    check("t1_empty", ascii_valid, 0);
    check("t1_zero", ascii_data, 0);

    do_reset();
    send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12,
               8'h58, 8'hF0, 8'h58, 8'h1C});
    pop_expect("t2_A0", 8'h41);
    pop_expect("t2_A1", 8'h41);
    check("t2_caps", caps_lock, 1);
    send_seq('{8'h12, 8'h1C});
    pop_expect("t2_shcaps", 8'h61);

    do_reset();
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12,
               8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0,
               8'h77, 8'h16});
    pop_expect("t3_up", 8'h80);
    pop_expect("t3_one", 8'h31);
    check("t3_empty", ascii_valid, 0);
    send(8'h21, 1);
    pop_expect("t3_noctrl", 8'h63);

    do_reset();
    send(8'h14, 1);
    send(8'h21, 5);
    pop_expect("t4_ctrlc", 8'h03);
    check("t4_once", ascii_valid, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) send(let_codes[i], 1);
    check("t5_full", fifo_full, 1);
    check("t5_noovf", overflow, 0);
    send_with_rd(let_codes[DEPTH]);
    check("t5_rw_full", fifo_full, 1);
    check("t5_rw_ovf", overflow, 0);
    for (int i = 1; i <= DEPTH; i++)
      pop_expect("t5_rw_rd", 8'h61 + 8'(i));
    check("t5_drain", ascii_valid, 0);

    do_reset();
    for (int i = 0; i <= DEPTH; i++) send(let_codes[i], 1);
    check("t5_full17", fifo_full, 1);
    check("t5_ovf17", overflow, 1);
    for (int i = 0; i < DEPTH; i++)
      pop_expect("t5_order", 8'h61 + 8'(i));
    check("t5_empty17", ascii_valid, 0);
    check("t5_ovf_sticky", overflow, 1);

    do_reset();
    send_seq('{8'hE0, 8'hF0});
    do_reset();
    check_reset_vals("t6_rst");
    send(8'h1C, 1);
    pop_expect("t6_a", 8'h61);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'hE0;
      else if (r < 22) b = 8'hF0;
      else if (r < 24) b = 8'hE1;
      else if (r < 38) begin
        case ($urandom_range(0, 3))
          0: b = 8'h12;
          1: b = 8'h59;
          2: b = 8'h14;
          default: b = 8'h58;
        endcase
      end
      else if (r < 65) b = let_codes[$urandom_range(0, 25)];
      else if (r < 75) b = dig_codes[$urandom_range(0, 9)];
      else if (r < 85) b = pun_codes[$urandom_range(0, 10)];
      else b = 8'($urandom);
      send(b, $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) pop();
      check("rnd_valid", ascii_valid, m_q.size() > 0);
      check("rnd_data", ascii_data,
            m_q.size() > 0 ? m_q[0] : 8'h00);
      check("rnd_full", fifo_full, m_q.size() == DEPTH);
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_caps", caps_lock, m_caps);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 Set-2 byte stream from the keyboard receiver (`scan_data` / `scan_data_valid`) into ASCII characters for the text-overlay writer. It tracks the following protocol and key state:
- make/break prefixes (F0);
- extended prefixes (E0);
- the Pause (E1) sequence;
- Shift, Ctrl and Caps Lock.

Decoded characters are buffered in a small first-word-fall-through FIFO read by the overlay character-entry logic.

## Interface
- `FIFO_DEPTH`, 16, number of buffered characters; power of two, 2..64.
- `clk`  input  1  system clock; same domain as the keyboard receiver.
- `reset`  input  1  synchronous, active-high; clears all state, modifiers and FIFO.
- `scan_data`  input  8  byte from the receiver; stable while `scan_data_valid` is high.
- `scan_data_valid`  input  1  receiver byte strobe; only its rising edge is significant.
- `ascii_data`  output  8  FIFO head character (FWFT); 0x00 when empty.
- `ascii_valid`  output  1  FIFO non-empty.
- `ascii_rd`  input  1  pops the head when `ascii_valid`=1; ignored when empty.
- `fifo_full`  output  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  output  1  sticky; set when a decoded character is dropped because the FIFO is full; cleared only by `reset`.
- `caps_lock`  output  1  current Caps Lock state, for a status LED or overlay indicator.

## Operation
Byte capture:
- A byte is taken on the cycle where `scan_data_valid`=1 and the previous sample was 0.
- A valid level held high for several cycles yields exactly one byte.

Prefix FSM states: IDLE, E0, F0, E0F0, SKIP.
- In IDLE:
  - byte E0 goes to E0;
  - byte F0 goes to F0;
  - byte E1 goes to SKIP with `skip_cnt`=7;
  - bytes AA, FA, FE, EE, 00, FF are ignored and the FSM stays in IDLE;
  - any other byte is a normal make code and returns to IDLE.
- In E0:
  - byte F0 goes to E0F0;
  - byte 12 (fake shift) is discarded and returns to IDLE;
  - any other byte is an extended make code and returns to IDLE.
- In F0: the byte is a normal break code; return to IDLE.
- In E0F0: the byte is an extended break code; return to IDLE.
- In SKIP: each byte decrements `skip_cnt`; return to IDLE when it reaches 0. No decode or modifier change happens during SKIP.

Modifier handling:
- Normal 12 and 59 set or clear `lshift` / `rshift` on make / break.
- Normal 14 and extended 14 set or clear `lctrl` / `rctrl`.
- Normal 58 toggles `caps_lock` on make only. Typematic repeats toggle again.

Character map (make codes only; break codes produce nothing):
- Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a–z.
  - Uppercase when (shift XOR `caps_lock`).
  - If either ctrl is held, output 0x01–0x1A instead, regardless of shift or caps.
- Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 0–9. With shift they map to `)!@#$%^&*(`.
- Punctuation, unshifted/shifted pairs:
  - 0E → `` ` `` / `~`
  - 4E → `-` / `_`
  - 55 → `=` / `+`
  - 54 → `[` / `{`
  - 5B → `]` / `}`
  - 5D → `\` / `|`
  - 4C → `;` / `:`
  - 52 → `'` / `"`
  - 41 → `,` / `<`
  - 49 → `.` / `>`
  - 4A → `/` / `?`
- Control keys:
  - 29 → 0x20 (space)
  - 5A → 0x0D
  - extended 5A → 0x0D
  - 66 → 0x08
  - 0D → 0x09
  - 76 → 0x1B
  - extended 71 → 0x7F
- Arrow keys: extended 75, 72, 6B, 74 map to 0x80 (up), 0x81 (down), 0x82 (left), 0x83 (right).
- All other codes are dropped silently.
- Typematic repeats of a mapped make code each produce a character.

FIFO:
- A write is accepted if not full, or if `ascii_rd` is asserted with `ascii_valid` in the same cycle.
- Otherwise the character is dropped and `overflow` is set.
- Read and write pointers wrap modulo `FIFO_DEPTH`. The occupancy counter is `clog2(FIFO_DEPTH)+1` bits wide.

## Timing
- Byte edge sampled at clock edge N: the decoded character is registered at N+1 and written to the FIFO at N+2. `ascii_valid` is high after N+2 when the FIFO was empty. The data path is 2 cycles.
- Modifier and FSM state updates at N+1, so the next byte (necessarily ≥2 cycles later) sees them.
- Pop: when `ascii_rd`=1 at edge M, the next entry (or 0x00 and `ascii_valid`=0) is presented after M.
- Simultaneous write and read when empty: the write wins and `ascii_valid` goes to 1.
- Reset values: FSM=IDLE, all modifiers=0, `caps_lock`=0, pointers=0, `ascii_data`=0x00, `ascii_valid`=0, `fifo_full`=0, `overflow`=0. The edge-detect register is also cleared.
- Reset takes priority over any simultaneous byte, mid-prefix or mid-SKIP.

## Test plan
- Sequence 1C, F0 1C → one entry 0x61 (`a`). After `ascii_rd`, `ascii_valid`=0.
- Sequence 12, 1C, F0 1C, F0 12, 58, F0 58, 1C → entries 0x41, 0x41, and `caps_lock`=1. Then 12, 1C → 0x61.
- Sequence E0 75, E0 F0 75, E0 12, E1 14 77 E1 F0 14 F0 77, 16 → entries 0x80 then 0x31 only. No ctrl is latched.
- Sequence 14, 21 → 0x03. Hold `scan_data_valid` high 5 cycles for one byte → exactly one character.
- With `FIFO_DEPTH`=16, write 17 chars with no reads → `fifo_full`=1, `overflow`=1, and the first 16 are read back in order. Full plus simultaneous read and write → no drop.
- Assert `reset` after E0 F0 → next 1C yields 0x61 (not treated as a break code). All outputs are at their reset values.
